// File: rtl/text_lcd_pkg.sv
// Shared types and timing defaults for the text LCD reader and writer.
// Reader state encoding and RS register-select constants live here too.
package text_lcd_pkg;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_SETUP,
    RD_E_HI_H,
    RD_E_LO_H,
    RD_E_HI_L,
    RD_E_LO_L,
    RD_DONE
  } rd_state_t;

  localparam logic LCD_RS_CMD  = 1'b0;
  localparam logic LCD_RS_DATA = 1'b1;

  localparam int TSU_CYC_DEF   = 4;
  localparam int EPW_CYC_DEF   = 25;
  localparam int EHOLD_CYC_DEF = 25;
  localparam int POLL_MAX_DEF  = 255;

endpackage

// File: rtl/text_lcd_phase_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// A load always wins over the decrement.
module text_lcd_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/text_lcd_reader.sv
// HD44780 4-bit read controller: busy/address or DDRAM/CGRAM byte reads.
// Define TEXT_LCD_READER_BUSY_POLL_EN to repeat RS=0 reads while BF=1.
module text_lcd_reader
  import text_lcd_pkg::*;
#(
  parameter int TSU_CYC   = TSU_CYC_DEF,
  parameter int EPW_CYC   = EPW_CYC_DEF,
  parameter int EHOLD_CYC = EHOLD_CYC_DEF,
  parameter int POLL_MAX  = POLL_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       req_rs,
  output logic       ready,
  input  logic [3:0] lcd_data_i,
  output logic       rs,
  output logic       rw,
  output logic       e,
  output logic       bus_rd,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy_flag,
  output logic [6:0] addr,
  output logic       poll_timeout
);

  if (TSU_CYC < 1 || EPW_CYC < 1 || EHOLD_CYC < 1 ||
      POLL_MAX < 1 || POLL_MAX > 255) begin : g_bad_param
    $error("text_lcd_reader: timing parameter out of range");
  end

  localparam logic [15:0] TSU_LD   = 16'(TSU_CYC - 1);
  localparam logic [15:0] EPW_LD   = 16'(EPW_CYC - 1);
  localparam logic [15:0] EHOLD_LD = 16'(EHOLD_CYC - 1);

  rd_state_t   state;
  logic        tmr_load;
  logic [15:0] tmr_val;
  logic        tmr_done;
  logic        repoll;

  text_lcd_phase_timer #(.W(16)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

`ifdef TEXT_LCD_READER_BUSY_POLL_EN
  localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);

  logic [7:0] poll_cnt;
  logic       give_up;
  logic       pt_q;

  assign repoll  = (rs == LCD_RS_CMD) && rd_data[7] &&
                   (poll_cnt != POLL_LAST);
  assign give_up = (rs == LCD_RS_CMD) && rd_data[7] &&
                   (poll_cnt == POLL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt <= '0;
      pt_q     <= 1'b0;
    end else begin
      pt_q <= (state == RD_DONE) && give_up;
      if (state == RD_DONE) begin
        poll_cnt <= repoll ? poll_cnt + 8'd1 : 8'd0;
      end
    end
  end

  assign poll_timeout = pt_q;
`else
  assign repoll       = 1'b0;
  assign poll_timeout = 1'b0;
`endif

  // Each phase loads its own length on entry.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TSU_LD;
    unique case (1'b1)
      (state == RD_IDLE): begin
        tmr_load = ready & req;
      end
      (state == RD_SETUP): begin
        tmr_load = tmr_done;
        tmr_val  = EPW_LD;
      end
      (state == RD_E_HI_H): begin
        tmr_load = tmr_done;
        tmr_val  = EHOLD_LD;
      end
      (state == RD_E_LO_H): begin
        tmr_load = tmr_done;
        tmr_val  = EPW_LD;
      end
      (state == RD_E_HI_L): begin
        tmr_load = tmr_done;
        tmr_val  = EHOLD_LD;
      end
      (state == RD_DONE): begin
        tmr_load = repoll;
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RD_IDLE;
      ready     <= 1'b1;
      rs        <= 1'b0;
      rw        <= 1'b0;
      e         <= 1'b0;
      bus_rd    <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      busy_flag <= 1'b0;
      addr      <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        RD_IDLE: begin
          if (!ready) begin
            ready <= 1'b1;
          end else if (req) begin
            ready  <= 1'b0;
            rs     <= req_rs;
            rw     <= 1'b1;
            bus_rd <= 1'b1;
            state  <= RD_SETUP;
          end
        end
        RD_SETUP: begin
          if (tmr_done) begin
            e     <= 1'b1;
            state <= RD_E_HI_H;
          end
        end
        RD_E_HI_H: begin
          if (tmr_done) begin
            rd_data[7:4] <= lcd_data_i;
            e            <= 1'b0;
            state        <= RD_E_LO_H;
          end
        end
        RD_E_LO_H: begin
          if (tmr_done) begin
            e     <= 1'b1;
            state <= RD_E_HI_L;
          end
        end
        RD_E_HI_L: begin
          if (tmr_done) begin
            rd_data[3:0] <= lcd_data_i;
            e            <= 1'b0;
            state        <= RD_E_LO_L;
          end
        end
        RD_E_LO_L: begin
          if (tmr_done) begin
            state <= RD_DONE;
          end
        end
        RD_DONE: begin
          if (rs == LCD_RS_CMD) begin
            busy_flag <= rd_data[7];
            addr      <= rd_data[6:0];
          end
          // A repeated poll keeps rs/rw/bus_rd and rereads.
          if (repoll) begin
            state <= RD_SETUP;
          end else begin
            rd_valid <= 1'b1;
            rw       <= 1'b0;
            bus_rd   <= 1'b0;
            state    <= RD_IDLE;
          end
        end
        default: begin
          state <= RD_IDLE;
        end
      endcase
    end
  end

endmodule
